regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Hazard controller that sequences access to the 32x32 general register file.
- Clocked on the decode clock. Tracks pending writebacks per destination register and stalls decode while a source operand is still in flight.
- Counts outstanding writes so the writeback stage can retire them out of the decode domain.
- x0 is never tracked, matching its hardwired-zero behaviour.

Parameters:
NREG, 32, number of architectural registers; index width is 5 bits.
CNT_W, 2, width of each per-register pending counter; maximum outstanding writes per register is 2^CNT_W-1 = 3.
TOT_W, 7, width of the total outstanding counter; must hold NREG*(2^CNT_W-1).

Ports:
RST  input  1  asynchronous active-low reset
CLK_DC  input  1  decode clock; all state updates on its rising edge
issue_valid  input  1  decode presents an instruction this cycle
issue_rs1  input  5  source register 1 index
issue_rs1_used  input  1  instruction reads rs1
issue_rs2  input  5  source register 2 index
issue_rs2_used  input  1  instruction reads rs2
issue_rd  input  5  destination register index
issue_rd_we  input  1  instruction writes rd
issue_accept  output  1  combinational: issue_valid && !stall
stall  output  1  combinational hazard indication to decode
retire_valid  input  1  writeback has committed a write
retire_rd  input  5  register written by that retire
flush  input  1  synchronous clear of all pending state (pipeline flush)
busy_mask  output  32  registered; bit i set when pending count of register i is nonzero
outstanding  output  TOT_W  registered total of pending writes
err_underflow  output  1  sticky; set on a retire to a register with zero pending

Behaviour:
- Reset (RST low, asynchronous): all counters 0, busy_mask 0, outstanding 0, err_underflow 0. Reset mid-operation discards every pending entry immediately.
- Per-register state is cnt[i], CNT_W bits. cnt[0] is held at 0 permanently.
- The stall term is computed from current registered counts only; a same-cycle retire does not unblock it. This is a deliberate one-cycle pessimism with no retire-to-issue bypass. stall is the OR of:
  - rs1 hazard: issue_valid && issue_rs1_used && issue_rs1!=0 && cnt[rs1]!=0
  - rs2 hazard: same condition for rs2
  - rd saturation: issue_valid && issue_rd_we && issue_rd!=0 && cnt[rd]==2^CNT_W-1
- stall is 0 whenever issue_valid=0.
- Issue increments: inc = issue_accept && issue_rd_we && issue_rd!=0. No RAW-on-self exception is needed, because rd hazard only stalls at saturation (WAW is allowed up to the limit).
- Retire decrements: dec = retire_valid && retire_rd!=0 && cnt[retire_rd]!=0.
- Retire underflow: retire_valid && retire_rd!=0 && cnt[retire_rd]==0 sets err_underflow. The retire is otherwise ignored and no counter changes. A retire to x0 is silently ignored.
- Same register, same cycle, both inc and dec: cnt unchanged and outstanding unchanged.
- Different registers, both events in the same cycle: each counter updates independently. outstanding is net unchanged.
- outstanding update is +1 on inc only, -1 on dec only, unchanged when both or neither occur.
- flush=1 clears all cnt, busy_mask and outstanding at the next edge. It has priority over inc and dec in that cycle. err_underflow is not cleared; only reset clears it.
- busy_mask and outstanding reflect post-update counts; they are registered and valid from the edge after the event.
- No wrap-around is permitted. Saturation stall guarantees cnt never exceeds 2^CNT_W-1, and the underflow guard guarantees cnt never goes below 0.

Test Plan:
1. Reset, then issue rd=5 with we=1 -> next cycle busy_mask=0x00000020, outstanding=1. Then issue rs1=5 used -> stall=1, issue_accept=0.
2. With cnt[5]=1, retire_rd=5 in cycle N while issuing rs1=5 -> stall=1 in cycle N. In cycle N+1 the same issue -> stall=0, busy_mask=0.
3. Issue rd=7 four times back-to-back with no retire -> first three accepted, cnt[7]=3, fourth stalls. A retire of 7 then allows the next issue.
4. Issue rd=0 with we=1 and rs1=0 used -> no stall, busy_mask stays 0, outstanding stays 0. A retire to 0 -> err_underflow stays 0.
5. Retire rd=9 with cnt[9]=0 -> err_underflow=1 and stays set. Then flush with 3 pending writes -> outstanding=0, busy_mask=0, err_underflow still 1.
6. Same-cycle issue rd=3 and retire rd=3 with cnt[3]=1 -> cnt[3]=1, outstanding unchanged. Assert RST low mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register-file hazard scoreboard for the decode stage.
// Keeps a small pending-write counter per architectural register, stalls
// decode while a source operand (or a saturated destination) is in flight,
// and exposes a busy mask plus a running total of outstanding writes.
// x0 is never tracked: its counter is held at zero permanently.
module regfile_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int TOT_W = 7
) (
  input  logic             RST,
  input  logic             CLK_DC,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic             issue_rs1_used,
  input  logic [4:0]       issue_rs2,
  input  logic             issue_rs2_used,
  input  logic [4:0]       issue_rd,
  input  logic             issue_rd_we,
  output logic             issue_accept,
  output logic             stall,
  input  logic             retire_valid,
  input  logic [4:0]       retire_rd,
  input  logic             flush,
  output logic [NREG-1:0]  busy_mask,
  output logic [TOT_W-1:0] outstanding,
  output logic             err_underflow
);

  // Largest count a register may reach; an issue at this level must stall.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [NREG-1:0]  busy_nxt;
  logic [TOT_W-1:0] outstanding_nxt;
  logic             rs1_hz;
  logic             rs2_hz;
  logic             rd_sat;
  logic             inc;
  logic             dec;
  logic             underflow;

  // Hazard and event decode from the registered counts only; a retire in the
  // same cycle deliberately does not release a stall (no retire bypass).
  always_comb begin
    rs1_hz       = issue_valid && issue_rs1_used && (issue_rs1 != 5'd0)
                   && (cnt[issue_rs1] != '0);
    rs2_hz       = issue_valid && issue_rs2_used && (issue_rs2 != 5'd0)
                   && (cnt[issue_rs2] != '0);
    rd_sat       = issue_valid && issue_rd_we && (issue_rd != 5'd0)
                   && (cnt[issue_rd] == CNT_MAX);
    stall        = rs1_hz || rs2_hz || rd_sat;
    issue_accept = issue_valid && !stall;
    inc          = issue_accept && issue_rd_we && (issue_rd != 5'd0);
    dec          = retire_valid && (retire_rd != 5'd0) && (cnt[retire_rd] != '0);
    underflow    = retire_valid && (retire_rd != 5'd0) && (cnt[retire_rd] == '0);
  end

  // Next counts, busy mask and total; flush wins over issue and retire.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    for (int i = 0; i < NREG; i++) cnt_nxt[i] = cnt[i];
    outstanding_nxt = outstanding;
    if (flush) begin
      for (int i = 0; i < NREG; i++) cnt_nxt[i] = '0;
      outstanding_nxt = '0;
    end else begin
      // Applied in sequence so an inc and dec on the same register cancel.
      if (inc) cnt_nxt[issue_rd]  = cnt_nxt[issue_rd] + CNT_W'(1);
      if (dec) cnt_nxt[retire_rd] = cnt_nxt[retire_rd] - CNT_W'(1);
      if (inc && !dec)      outstanding_nxt = outstanding + TOT_W'(1);
      else if (dec && !inc) outstanding_nxt = outstanding - TOT_W'(1);
    end
    cnt_nxt[0] = '0;
    for (int i = 0; i < NREG; i++) busy_nxt[i] = (cnt_nxt[i] != '0);
  end

  // State registers; the sticky error survives flush and clears only on reset.
  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      // NOTE: the counter array is real state that must start empty, so it is
      // reset element by element rather than left to a RAM-style power-up.
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      busy_mask     <= '0;
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
      busy_mask   <= busy_nxt;
      outstanding <= outstanding_nxt;
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule
